// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared encodings and geometry helpers for the set-associative array
package cache_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP     = 2'd0,
        OP_WRITE      = 2'd1,
        OP_FILL       = 2'd2,
        OP_INVALIDATE = 2'd3
    } op_e;

    // Stored status word per way/set is {tag, valid, dirty}
    localparam int ST_DIRTY = 0;
    localparam int ST_VALID = 1;
    localparam int ST_W     = 2;

    function automatic int line_bits(input int offset_w);
        return 8 * (1 << offset_w);
    endfunction

    function automatic int line_words(input int offset_w);
        return 1 << (offset_w - 2);
    endfunction

    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_plru.sv
// rtl/cache_plru.sv - per-set tree pseudo-LRU bits with combinational victim
module cache_plru
    import cache_pkg::*;
#(
    parameter int INDEX_W = 10,
    parameter int WAYS    = 2,
    localparam int WAY_W  = way_bits(WAYS)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [INDEX_W-1:0] clr_idx,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic [WAY_W-1:0]   victim,
    input  logic               touch,
    input  logic [INDEX_W-1:0] touch_idx,
    input  logic [WAY_W-1:0]   touch_way
);
    localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;

    logic [PW-1:0] bits_mem [1 << INDEX_W];

    // Tree bit 0 picks the half (0 = ways 0/1), bits 1/2 pick within each half
    function automatic logic [PW-1:0] point_away(input logic [PW-1:0] b, input logic [WAY_W-1:0] w);
        logic [2:0] r;
        logic [1:0] w2;
        r  = 3'(b);
        w2 = 2'(w);
        if (WAYS == 2) begin
            r[0] = ~w2[0];
        end else if (WAYS == 4) begin
            r[0] = ~w2[1];
            if (w2[1]) r[2] = ~w2[0];
            else       r[1] = ~w2[0];
        end
        return PW'(r);
    endfunction

    // Sweep-clear has priority; otherwise a touch steers the tree away from the used way
    always_ff @(posedge clk) begin
        if (clr) begin
            bits_mem[clr_idx] <= '0;
        end else if (touch) begin
            bits_mem[touch_idx] <= point_away(bits_mem[touch_idx], touch_way);
        end
    end

    // Follow the tree from the root to the replacement candidate
    always_comb begin
        logic [2:0] b;
        logic [1:0] v;
        b = 3'(bits_mem[rd_idx]);
        v = 2'b00;
        if (WAYS == 2) begin
            v = {1'b0, b[0]};
        end else if (WAYS == 4) begin
            v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
        end
        victim = WAY_W'(v);
    end

endmodule

// File: rtl/cache_set_assoc_array.sv
// rtl/cache_set_assoc_array.sv - N-way set-associative tag/data array with pLRU replacement
module cache_set_assoc_array
    import cache_pkg::*;
#(
    parameter int TAG_W    = 13,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 4,
    parameter int WAYS     = 2,
    localparam int WAY_W   = way_bits(WAYS),
    localparam int LINE    = line_bits(OFFSET_W),
    localparam int ADDR_W  = TAG_W + INDEX_W + OFFSET_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    input  logic [WAY_W-1:0]  req_way,
    input  logic [LINE-1:0]   req_line,
    input  logic              req_dirty,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [WAY_W-1:0]  resp_way,
    output logic [31:0]       resp_rdata,
    output logic [TAG_W-1:0]  resp_victim_tag,
    output logic              resp_victim_valid,
    output logic              resp_victim_dirty,
    output logic [LINE-1:0]   resp_victim_line
);
    localparam int SETS = 1 << INDEX_W;
    localparam int WI_W = OFFSET_W - 2;
    localparam int TS_W = TAG_W + ST_W;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RESP, S_WBUSY} state_e;

    state_e             state, state_nxt;
    logic [INDEX_W-1:0] clr_idx;
    logic               accept;
    logic [INDEX_W-1:0] rd_idx;

    op_e                op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] idx_q;
    logic [WI_W-1:0]    widx_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic [WAY_W-1:0]   fway_q;
    logic [LINE-1:0]    fline_q;
    logic               fdirty_q;

    logic [TS_W-1:0]    ts_rd   [WAYS];
    logic [LINE-1:0]    line_rd [WAYS];
    logic [WAYS-1:0]    ts_we, line_we;
    logic [INDEX_W-1:0] wr_idx;
    logic [TS_W-1:0]    ts_wr;
    logic [LINE-1:0]    line_wr;
    logic [LINE-1:0]    merged;

    logic               hit, inv_found;
    logic [WAY_W-1:0]   hit_way, inv_way, plru_way, victim_way, rep_way;
    logic               plru_touch;
    logic [WAY_W-1:0]   plru_touch_way;
    logic               unused_byte_bits;

    assign rd_idx           = req_addr[OFFSET_W +: INDEX_W];
    assign accept           = req_valid && req_ready;
    assign unused_byte_bits = ^req_addr[1:0];

    // State register and clear-sweep counter; reset restarts the sweep at set 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
        end
    end

    // Next state and request handshake; back-to-back lookups keep ready high in RESP
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        unique case (state)
            S_CLEAR: if (&clr_idx) state_nxt = S_IDLE;
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (op_q == OP_LOOKUP) begin
                    req_ready = 1'b1;
                    state_nxt = req_valid ? S_RESP : S_IDLE;
                end else begin
                    state_nxt = S_WBUSY;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (reset) req_ready = 1'b0;
    end

    // Capture the request at accept so later input changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= op_e'(req_op);
            tag_q    <= req_addr[ADDR_W-1 -: TAG_W];
            idx_q    <= rd_idx;
            widx_q   <= req_addr[OFFSET_W-1:2];
            wdata_q  <= req_wdata;
            wstrb_q  <= req_wstrb;
            fway_q   <= req_way;
            fline_q  <= req_line;
            fdirty_q <= req_dirty;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [TS_W-1:0] ts_mem   [SETS];
        logic [LINE-1:0] line_mem [SETS];
        logic [TS_W-1:0] ts_q;
        logic [LINE-1:0] line_q;

        // One write port for sweep/commit, registered read of the accepted set
        always_ff @(posedge clk) begin
            if (ts_we[w])   ts_mem[wr_idx]   <= ts_wr;
            if (line_we[w]) line_mem[wr_idx] <= line_wr;
            if (accept) begin
                ts_q   <= ts_mem[rd_idx];
                line_q <= line_mem[rd_idx];
            end
        end

        assign ts_rd[w]   = ts_q;
        assign line_rd[w] = line_q;
    end

    // Tag compare (lowest matching way wins) and lowest invalid way
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && ts_rd[w][ST_VALID] && ts_rd[w][ST_W +: TAG_W] == tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !ts_rd[w][ST_VALID]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_way = inv_found ? inv_way : plru_way;
        rep_way    = (op_q == OP_INVALIDATE && hit) ? hit_way : victim_way;
    end

    // Byte-strobe merge of the write word into the hit line
    always_comb begin
        merged = line_rd[hit_way];
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) merged[32*int'(widx_q) + 8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    // RAM write selection: clear sweep, or the commit at the end of RESP
    always_comb begin
        ts_we   = '0;
        line_we = '0;
        wr_idx  = idx_q;
        ts_wr   = '0;
        line_wr = '0;
        if (!reset) begin
            if (state == S_CLEAR) begin
                ts_we   = '1;
                line_we = '1;
                wr_idx  = clr_idx;
            end else if (state == S_RESP) begin
                unique case (op_q)
                    OP_WRITE: if (hit) begin
                        ts_we[hit_way]   = 1'b1;
                        line_we[hit_way] = 1'b1;
                        ts_wr            = {tag_q, 2'b11};
                        line_wr          = merged;
                    end
                    OP_FILL: begin
                        ts_we[fway_q]   = 1'b1;
                        line_we[fway_q] = 1'b1;
                        ts_wr           = {tag_q, 1'b1, fdirty_q};
                        line_wr         = fline_q;
                    end
                    OP_INVALIDATE: if (hit) begin
                        ts_we[hit_way] = 1'b1;
                        ts_wr          = {ts_rd[hit_way][ST_W +: TAG_W], 2'b00};
                    end
                    default: ;
                endcase
            end
        end
    end

    // Replacement state is touched by hitting lookups/writes and by fills
    always_comb begin
        plru_touch     = 1'b0;
        plru_touch_way = hit_way;
        if (!reset && state == S_RESP) begin
            if (op_q == OP_FILL) begin
                plru_touch     = 1'b1;
                plru_touch_way = fway_q;
            end else if ((op_q == OP_LOOKUP || op_q == OP_WRITE) && hit) begin
                plru_touch = 1'b1;
            end
        end
    end

    cache_plru #(
        .INDEX_W (INDEX_W),
        .WAYS    (WAYS)
    ) u_plru (
        .clk       (clk),
        .clr       (state == S_CLEAR),
        .clr_idx   (clr_idx),
        .rd_idx    (idx_q),
        .victim    (plru_way),
        .touch     (plru_touch),
        .touch_idx (idx_q),
        .touch_way (plru_touch_way)
    );

    // Response is presented in RESP only; everything reads zero otherwise
    always_comb begin
        resp_valid        = 1'b0;
        resp_hit          = 1'b0;
        resp_way          = '0;
        resp_rdata        = '0;
        resp_victim_tag   = '0;
        resp_victim_valid = 1'b0;
        resp_victim_dirty = 1'b0;
        resp_victim_line  = '0;
        if (state == S_RESP && !reset) begin
            resp_valid = 1'b1;
            if (op_q == OP_FILL) begin
                resp_hit   = 1'b1;
                resp_way   = fway_q;
                resp_rdata = fline_q[32*int'(widx_q) +: 32];
            end else begin
                resp_hit   = hit;
                resp_way   = hit ? hit_way : victim_way;
                resp_rdata = hit ? line_rd[hit_way][32*int'(widx_q) +: 32] : 32'h0;
            end
            resp_victim_tag   = ts_rd[rep_way][ST_W +: TAG_W];
            resp_victim_valid = ts_rd[rep_way][ST_VALID];
            resp_victim_dirty = ts_rd[rep_way][ST_DIRTY];
            resp_victim_line  = line_rd[rep_way];
        end
    end

endmodule

// File: tb/tb_cache_set_assoc_array.sv
// tb/tb_cache_set_assoc_array.sv - scoreboard bench for cache_set_assoc_array
module tb_cache_set_assoc_array;
    import cache_pkg::*;

    localparam int SETS = 1024;
    localparam int NW   = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [26:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wstrb;
    logic [0:0]   req_way;
    logic [127:0] req_line;
    logic         req_dirty;
    logic         resp_valid;
    logic         resp_hit;
    logic [0:0]   resp_way;
    logic [31:0]  resp_rdata;
    logic [12:0]  resp_victim_tag;
    logic         resp_victim_valid;
    logic         resp_victim_dirty;
    logic [127:0] resp_victim_line;

    cache_set_assoc_array dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_wstrb         (req_wstrb),
        .req_way           (req_way),
        .req_line          (req_line),
        .req_dirty         (req_dirty),
        .resp_valid        (resp_valid),
        .resp_hit          (resp_hit),
        .resp_way          (resp_way),
        .resp_rdata        (resp_rdata),
        .resp_victim_tag   (resp_victim_tag),
        .resp_victim_valid (resp_victim_valid),
        .resp_victim_dirty (resp_victim_dirty),
        .resp_victim_line  (resp_victim_line)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         hit;
        logic [0:0]   way;
        logic [31:0]  rdata;
        logic [12:0]  vtag;
        logic         vvalid;
        logic         vdirty;
        logic [127:0] vline;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_resp_cyc = -10;
    int   prev_resp_cyc = -10;

    // Reference contents: what each set/way holds, plus the most recently used way
    bit           m_valid [SETS][NW];
    bit           m_dirty [SETS][NW];
    logic [12:0]  m_tag   [SETS][NW];
    logic [127:0] m_line  [SETS][NW];
    int           m_mru   [SETS];

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tag[s][w]   = '0;
                m_line[s][w]  = '0;
            end
            m_mru[s] = 0;
        end
    endtask

    task automatic model_op(input logic [1:0] op, input logic [26:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [0:0] way, input logic [127:0] line,
                            input logic dirty, output exp_t e);
        int tag, set, wi, hw, vw, rep;
        tag = int'(addr[26:14]);
        set = int'(addr[13:4]);
        wi  = int'(addr[3:2]);
        hw  = -1;
        vw  = -1;
        for (int w = 0; w < NW; w++) begin
            if (hw < 0 && m_valid[set][w] && int'(m_tag[set][w]) == tag) hw = w;
            if (vw < 0 && !m_valid[set][w]) vw = w;
        end
        if (vw < 0) vw = 1 - m_mru[set];
        rep = (op == OP_INVALIDATE && hw >= 0) ? hw : vw;
        e.vtag   = m_tag[set][rep];
        e.vvalid = m_valid[set][rep];
        e.vdirty = m_dirty[set][rep];
        e.vline  = m_line[set][rep];
        e.hit    = (hw >= 0);
        e.way    = (hw >= 0) ? 1'(hw) : 1'(vw);
        e.rdata  = (hw >= 0) ? m_line[set][hw][32*wi +: 32] : 32'h0;
        case (op)
            OP_LOOKUP: if (hw >= 0) m_mru[set] = hw;
            OP_WRITE: if (hw >= 0) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) m_line[set][hw][32*wi + 8*b +: 8] = wdata[8*b +: 8];
                m_dirty[set][hw] = 1;
                m_mru[set] = hw;
            end
            OP_FILL: begin
                e.hit   = 1'b1;
                e.way   = way;
                e.rdata = line[32*wi +: 32];
                m_valid[set][way] = 1;
                m_dirty[set][way] = dirty;
                m_tag[set][way]   = addr[26:14];
                m_line[set][way]  = line;
                m_mru[set]        = int'(way);
            end
            default: if (hw >= 0) begin
                m_valid[set][hw] = 0;
                m_dirty[set][hw] = 0;
            end
        endcase
    endtask

    // Monitor: every presented response is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("resp_hit", resp_hit, e.hit);
                check("resp_way", resp_way, e.way);
                check("resp_rdata", resp_rdata, e.rdata);
                check("victim_tag", resp_victim_tag, e.vtag);
                check("victim_valid", resp_victim_valid, e.vvalid);
                check("victim_dirty", resp_victim_dirty, e.vdirty);
                check("victim_line", resp_victim_line, e.vline);
            end
            prev_resp_cyc = last_resp_cyc;
            last_resp_cyc = cyc;
        end
    end

    task automatic send(input logic [1:0] op, input logic [26:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [0:0] way, input logic [127:0] line,
                        input logic dirty);
        exp_t e;
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        req_way   = way;
        req_line  = line;
        req_dirty = dirty;
        req_valid = 1'b1;
        model_op(op, addr, wdata, wstrb, way, line, dirty, e);
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 27'($urandom);
        req_line  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic count_sweep();
        int n = 0;
        #1;
        while (!req_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("sweep_cycles", n, 1024);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        logic [127:0] ln;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; req_way = '0; req_line = '0; req_dirty = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("ready_in_reset", req_ready, 0);
        reset = 1'b0;
        count_sweep();

        send(OP_LOOKUP, 27'h0012340, 0, 0, 0, 0, 0);
        ln = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
        send(OP_FILL, 27'h0004010, 0, 0, 1, ln, 0);
        send(OP_LOOKUP, 27'h0004014, 0, 0, 0, 0, 0);
        send(OP_WRITE, 27'h0004014, 32'h11223344, 4'b0101, 0, 0, 0);
        send(OP_LOOKUP, 27'h0004014, 0, 0, 0, 0, 0);
        send(OP_FILL, 27'h0008010, 0, 0, 0, {4{32'hA5A50000}}, 0);
        send(OP_LOOKUP, 27'h0008018, 0, 0, 0, 0, 0);
        send(OP_LOOKUP, 27'h000C010, 0, 0, 0, 0, 0);
        send(OP_INVALIDATE, 27'h0004010, 0, 0, 0, 0, 0);
        send(OP_LOOKUP, 27'h0004014, 0, 0, 0, 0, 0);
        send(OP_LOOKUP, 27'h0008010, 0, 0, 0, 0, 0);
        send(OP_LOOKUP, 27'h0004010, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("back_to_back_gap", last_resp_cyc - prev_resp_cyc, 1);

        for (int i = 0; i < 300; i++) begin
            logic [26:0] a;
            a = {13'($urandom_range(0, 3)), 10'($urandom_range(0, 3)), 4'($urandom)};
            send(2'($urandom_range(0, 3)), a, $urandom, 4'($urandom), 1'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
        end

        send(OP_FILL, 27'h0010020, 0, 0, 0, {4{32'h5EED1234}}, 1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        count_sweep();
        send(OP_LOOKUP, 27'h0010020, 0, 0, 0, 0, 0);
        send(OP_LOOKUP, 27'h0008010, 0, 0, 0, 0, 0);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
